// File: rtl/rs_pkg.sv
// Shared widths, entry layout and ROB-distance helper for the reservation station.
package rs_pkg;

  localparam int unsigned RS_NUM_ROB   = 32;
  localparam int unsigned RS_ROB_W     = $clog2(RS_NUM_ROB);
  localparam int unsigned RS_NUM_PR    = 64;
  localparam int unsigned RS_PR_W      = $clog2(RS_NUM_PR);
  localparam int unsigned RS_ZERO_PR   = 31;
  localparam int unsigned RS_PAYLOAD_W = 128;

  typedef struct packed {
    logic [RS_PR_W-1:0] idx;
    logic               ready;
  } RS_TAG_t;

  typedef struct packed {
    logic                    busy;
    logic [RS_ROB_W-1:0]     rob_idx;
    logic [RS_PAYLOAD_W-1:0] payload;
    RS_TAG_t                 t1;
    RS_TAG_t                 t2;
  } RS_ENTRY_t;

  localparam RS_ENTRY_t RS_ENTRY_RESET = '0;

  // Distance from ref to idx in ROB order, wrapping modulo the ROB depth.
  function automatic logic [RS_ROB_W-1:0] rob_dist(input logic [RS_ROB_W-1:0] idx,
                                                   input logic [RS_ROB_W-1:0] ref_idx);
    return idx - ref_idx;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first picker: binary reduction tree over (request, age) pairs.
module rs_age_select #(
  parameter int unsigned N     = 8,
  parameter int unsigned AGE_W = 5
) (
  input  logic [N-1:0]         req_i,
  input  logic [N*AGE_W-1:0]   age_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IDX_W = $clog2(N);

  // Heap-ordered tree: node k has children 2k and 2k+1, leaves at N..2N-1.
  logic             nv [2*N];
  logic [AGE_W-1:0] na [2*N];
  logic [IDX_W-1:0] ni [2*N];
  logic             take_left;

  always_comb begin
    take_left = 1'b0;
    for (int unsigned k = 0; k < 2*N; k++) begin
      nv[k] = 1'b0;
      na[k] = '0;
      ni[k] = '0;
    end
    for (int unsigned i = 0; i < N; i++) begin
      nv[N+i] = req_i[i];
      na[N+i] = age_i[i*AGE_W +: AGE_W];
      ni[N+i] = IDX_W'(i);
    end
    for (int unsigned k = N-1; k >= 1; k--) begin
      take_left = nv[2*k] && (!nv[2*k+1] || (na[2*k] <= na[2*k+1]));
      nv[k] = nv[2*k] | nv[2*k+1];
      na[k] = take_left ? na[2*k] : na[2*k+1];
      ni[k] = take_left ? ni[2*k] : ni[2*k+1];
    end
  end

  assign any_o = nv[1];
  assign idx_o = ni[1];

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++)
      gnt_o[i] = any_o && (ni[1] == IDX_W'(i));
  end

endmodule

// File: rtl/rs_multi_issue.sv
// Reservation station: CDB wakeup, oldest-ready issue in ROB order, rollback squash.
module rs_multi_issue
  import rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_CDB     = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          dispatch_en,
  input  logic [RS_PAYLOAD_W-1:0]       dispatch_payload,
  input  logic [RS_ROB_W-1:0]           dispatch_rob_idx,
  input  logic [RS_PR_W-1:0]            dispatch_T1_idx,
  input  logic [RS_PR_W-1:0]            dispatch_T2_idx,
  input  logic                          dispatch_T1_ready,
  input  logic                          dispatch_T2_ready,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*RS_PR_W-1:0]    cdb_T_idx,
  input  logic [RS_ROB_W-1:0]           rob_head_idx,
  input  logic                          rollback_en,
  input  logic [RS_ROB_W-1:0]           rollback_rob_idx,
  input  logic [RS_ROB_W-1:0]           rollback_diff,
  input  logic                          issue_ready,
  output logic                          issue_valid,
  output logic [RS_PAYLOAD_W-1:0]       issue_payload,
  output logic [RS_ROB_W-1:0]           issue_rob_idx,
  output logic [RS_PR_W-1:0]            issue_T1_idx,
  output logic [RS_PR_W-1:0]            issue_T2_idx,
  output logic                          rs_ready,
  output logic [$clog2(NUM_ENTRIES):0]  free_count
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [RS_PR_W-1:0] ZERO_TAG = RS_PR_W'(RS_ZERO_PR);

  RS_ENTRY_t ent_q [NUM_ENTRIES];
  RS_ENTRY_t ent_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]          hit1, hit2, squash, cand, gnt;
  logic [NUM_ENTRIES*RS_ROB_W-1:0] age_flat;
  logic [IDX_W-1:0]                sel_idx, alloc_idx;
  logic                            sel_any, alloc_found, dhit1, dhit2, fire, do_disp;
  logic [CNT_W-1:0]                free_cnt;

  // Tag matches against stored entries and against the instruction being dispatched.
  always_comb begin
    hit1  = '0;
    hit2  = '0;
    dhit1 = 1'b0;
    dhit2 = 1'b0;
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && (cdb_T_idx[p*RS_PR_W +: RS_PR_W] != ZERO_TAG)) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (cdb_T_idx[p*RS_PR_W +: RS_PR_W] == ent_q[i].t1.idx) hit1[i] = 1'b1;
          if (cdb_T_idx[p*RS_PR_W +: RS_PR_W] == ent_q[i].t2.idx) hit2[i] = 1'b1;
        end
        if (cdb_T_idx[p*RS_PR_W +: RS_PR_W] == dispatch_T1_idx) dhit1 = 1'b1;
        if (cdb_T_idx[p*RS_PR_W +: RS_PR_W] == dispatch_T2_idx) dhit2 = 1'b1;
      end
    end
  end

  always_comb begin
    squash   = '0;
    cand     = '0;
    age_flat = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      squash[i] = ent_q[i].busy && rollback_en &&
                  (rob_dist(ent_q[i].rob_idx, rollback_rob_idx) <= rollback_diff);
      cand[i]   = ent_q[i].busy && ent_q[i].t1.ready && ent_q[i].t2.ready && !squash[i];
      age_flat[i*RS_ROB_W +: RS_ROB_W] = rob_dist(ent_q[i].rob_idx, rob_head_idx);
    end
  end

  rs_age_select #(
    .N     (NUM_ENTRIES),
    .AGE_W (RS_ROB_W)
  ) u_sel (
    .req_i (cand),
    .age_i (age_flat),
    .gnt_o (gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign issue_valid   = en && sel_any;
  assign issue_payload = ent_q[sel_idx].payload;
  assign issue_rob_idx = ent_q[sel_idx].rob_idx;
  assign issue_T1_idx  = ent_q[sel_idx].t1.idx;
  assign issue_T2_idx  = ent_q[sel_idx].t2.idx;
  assign fire          = issue_valid && issue_ready;

  // Free count and lowest free slot come from registered state only.
  always_comb begin
    free_cnt    = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!ent_q[i].busy) free_cnt = free_cnt + CNT_W'(1);
    end
    for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
      if (!ent_q[i-1].busy) begin
        alloc_idx   = IDX_W'(i-1);
        alloc_found = 1'b1;
      end
    end
  end

  assign free_count = free_cnt;
  assign rs_ready   = (free_cnt != '0);
  assign do_disp    = dispatch_en && rs_ready && en && !rollback_en && alloc_found;

  always_comb begin
    ent_d = ent_q;
    if (en) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (squash[i]) begin
          ent_d[i] = RS_ENTRY_RESET;
        end else if (fire && gnt[i]) begin
          ent_d[i] = RS_ENTRY_RESET;
        end else if (ent_q[i].busy) begin
          ent_d[i].t1.ready = ent_q[i].t1.ready | hit1[i];
          ent_d[i].t2.ready = ent_q[i].t2.ready | hit2[i];
        end else if (do_disp && (alloc_idx == IDX_W'(i))) begin
          ent_d[i].busy     = 1'b1;
          ent_d[i].rob_idx  = dispatch_rob_idx;
          ent_d[i].payload  = dispatch_payload;
          ent_d[i].t1.idx   = dispatch_T1_idx;
          ent_d[i].t1.ready = dispatch_T1_ready | dhit1;
          ent_d[i].t2.idx   = dispatch_T2_idx;
          ent_d[i].t2.ready = dispatch_T2_ready | dhit2;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= RS_ENTRY_RESET;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed bench for rs_multi_issue with an issue-order scoreboard.
module tb_rs_multi_issue;
  import rs_pkg::*;

  logic         clock = 1'b0;
  logic         reset, en, dispatch_en;
  logic [127:0] dispatch_payload;
  logic [4:0]   dispatch_rob_idx;
  logic [5:0]   dispatch_T1_idx, dispatch_T2_idx;
  logic         dispatch_T1_ready, dispatch_T2_ready;
  logic [1:0]   cdb_valid;
  logic [11:0]  cdb_T_idx;
  logic [4:0]   rob_head_idx, rollback_rob_idx, rollback_diff;
  logic         rollback_en, issue_ready;
  logic         issue_valid, rs_ready;
  logic [127:0] issue_payload;
  logic [4:0]   issue_rob_idx;
  logic [5:0]   issue_T1_idx, issue_T2_idx;
  logic [3:0]   free_count;

  typedef struct {
    logic [4:0] rob;
    logic [5:0] t1;
    logic [5:0] t2;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  rs_multi_issue #(.NUM_ENTRIES(8), .NUM_CDB(2)) dut (
    .clock(clock), .reset(reset), .en(en),
    .dispatch_en(dispatch_en), .dispatch_payload(dispatch_payload),
    .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_T1_idx(dispatch_T1_idx), .dispatch_T2_idx(dispatch_T2_idx),
    .dispatch_T1_ready(dispatch_T1_ready), .dispatch_T2_ready(dispatch_T2_ready),
    .cdb_valid(cdb_valid), .cdb_T_idx(cdb_T_idx), .rob_head_idx(rob_head_idx),
    .rollback_en(rollback_en), .rollback_rob_idx(rollback_rob_idx),
    .rollback_diff(rollback_diff), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_payload(issue_payload),
    .issue_rob_idx(issue_rob_idx), .issue_T1_idx(issue_T1_idx),
    .issue_T2_idx(issue_T2_idx), .rs_ready(rs_ready), .free_count(free_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [127:0] pl(input logic [4:0] rob);
    return {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_0000 | 32'(rob), 27'h0, rob};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input logic [4:0] rob, input logic [5:0] t1, input logic t1r,
                          input logic [5:0] t2, input logic t2r);
    dispatch_rob_idx  = rob;
    dispatch_payload  = pl(rob);
    dispatch_T1_idx   = t1;
    dispatch_T1_ready = t1r;
    dispatch_T2_idx   = t2;
    dispatch_T2_ready = t2r;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [5:0] t1, input logic t1r,
                      input logic [5:0] t2, input logic t2r);
    set_disp(rob, t1, t1r, t2, t2r);
    dispatch_en = 1'b1;
    step();
    dispatch_en = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rob, input logic [5:0] t1, input logic [5:0] t2);
    exp_t e;
    e.rob = rob;
    e.t1  = t1;
    e.t2  = t2;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for an offer, accepts it and compares against the scoreboard head.
  task automatic expect_issue(input string tag);
    exp_t e;
    int   w = 0;
    while (!issue_valid && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_valid"}, 128'(issue_valid), 128'(1'b1));
    if (exp_q.size() == 0) begin
      $display("FAIL %s_scoreboard: observed empty expected entry", tag);
      $fatal(1);
    end
    e = exp_q.pop_front();
    issue_ready = 1'b1;
    #1;
    chk({tag, "_rob"},     128'(issue_rob_idx), 128'(e.rob));
    chk({tag, "_t1"},      128'(issue_T1_idx),  128'(e.t1));
    chk({tag, "_t2"},      128'(issue_T2_idx),  128'(e.t2));
    chk({tag, "_payload"}, issue_payload,       pl(e.rob));
    step();
    issue_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; dispatch_en = 1'b0; issue_ready = 1'b0;
    cdb_valid = '0; cdb_T_idx = '0; rob_head_idx = '0;
    rollback_en = 1'b0; rollback_rob_idx = '0; rollback_diff = '0;
    set_disp(5'd0, 6'd0, 1'b0, 6'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_issue_valid", 128'(issue_valid), 128'(1'b0));
    chk("rst_free_count",  128'(free_count),  128'(4'd8));
    chk("rst_rs_ready",    128'(rs_ready),    128'(1'b1));

    // Same-cycle CDB hit captured at dispatch
    cdb_valid = 2'b01;
    cdb_T_idx = {6'd0, 6'd5};
    set_disp(5'd0, 6'd5, 1'b0, 6'd6, 1'b1);
    dispatch_en = 1'b1;
    #1 chk("disp_same_cycle_valid", 128'(issue_valid), 128'(1'b0));
    step();
    dispatch_en = 1'b0;
    cdb_valid = '0;
    chk("disp_next_cycle_valid", 128'(issue_valid), 128'(1'b1));
    push_exp(5'd0, 6'd5, 6'd6);
    expect_issue("disp_wake");
    chk("disp_freed", 128'(free_count), 128'(4'd8));

    // Fill, overflow dispatch, drain
    for (int r = 0; r < 8; r++) disp(5'(r), 6'd40, 1'b0, 6'd41, 1'b1);
    chk("full_rs_ready",   128'(rs_ready),   128'(1'b0));
    chk("full_free_count", 128'(free_count), 128'(4'd0));
    disp(5'd8, 6'd1, 1'b1, 6'd2, 1'b1);
    chk("overflow_ignored", 128'(free_count),  128'(4'd0));
    chk("overflow_no_issue", 128'(issue_valid), 128'(1'b0));
    cdb_valid = 2'b10;
    cdb_T_idx = {6'd40, 6'd0};
    step();
    cdb_valid = '0;
    chk("fill_woken", 128'(issue_valid), 128'(1'b1));
    for (int r = 0; r < 3; r++) push_exp(5'(r), 6'd40, 6'd41);
    expect_issue("fill0");
    chk("after_issue_rs_ready", 128'(rs_ready),   128'(1'b1));
    chk("after_issue_free",     128'(free_count), 128'(4'd1));
    expect_issue("fill1");
    expect_issue("fill2");
    chk("five_busy_free", 128'(free_count), 128'(4'd3));

    // Asynchronous reset mid-operation
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 128'(issue_valid), 128'(1'b0));
    chk("async_rst_free",  128'(free_count),  128'(4'd8));
    chk("async_rst_ready", 128'(rs_ready),    128'(1'b1));
    @(posedge clock);
    #1 reset = 1'b0;

    // Oldest-first across ROB wrap
    rob_head_idx = 5'd30;
    disp(5'd1,  6'd10, 1'b1, 6'd11, 1'b1);
    disp(5'd31, 6'd12, 1'b1, 6'd13, 1'b1);
    disp(5'd3,  6'd14, 1'b1, 6'd15, 1'b1);
    push_exp(5'd31, 6'd12, 6'd13);
    push_exp(5'd1,  6'd10, 6'd11);
    push_exp(5'd3,  6'd14, 6'd15);
    expect_issue("wrap_a");
    expect_issue("wrap_b");
    expect_issue("wrap_c");
    chk("wrap_drained", 128'(issue_valid), 128'(1'b0));
    chk("wrap_free",    128'(free_count),  128'(4'd8));

    // ZERO_PR broadcast must not wake; dual-port wakeup
    rob_head_idx = 5'd0;
    disp(5'd6, 6'd31, 1'b0, 6'd2, 1'b1);
    cdb_valid = 2'b01;
    cdb_T_idx = {6'd0, 6'd31};
    step();
    cdb_valid = '0;
    chk("zero_pr_no_wake", 128'(issue_valid), 128'(1'b0));
    disp(5'd5, 6'd7, 1'b0, 6'd9, 1'b0);
    cdb_valid = 2'b11;
    cdb_T_idx = {6'd9, 6'd7};
    #1 chk("dual_same_cycle", 128'(issue_valid), 128'(1'b0));
    step();
    cdb_valid = '0;
    chk("dual_next_cycle", 128'(issue_valid), 128'(1'b1));
    push_exp(5'd5, 6'd7, 6'd9);
    expect_issue("dual");
    chk("zero_pr_still_blocked", 128'(issue_valid), 128'(1'b0));
    reset = 1'b1;
    step();
    reset = 1'b0;

    // en low freeze, then rollback squash
    rob_head_idx = 5'd12;
    disp(5'd9,  6'd20, 1'b1, 6'd21, 1'b1);
    disp(5'd10, 6'd50, 1'b0, 6'd22, 1'b1);
    disp(5'd14, 6'd23, 1'b1, 6'd24, 1'b1);
    disp(5'd15, 6'd51, 1'b0, 6'd25, 1'b1);
    chk("rb_pre_free", 128'(free_count), 128'(4'd4));
    en = 1'b0;
    set_disp(5'd20, 6'd1, 1'b1, 6'd2, 1'b1);
    dispatch_en = 1'b1;
    #1 chk("en_low_valid", 128'(issue_valid), 128'(1'b0));
    step();
    dispatch_en = 1'b0;
    en = 1'b1;
    chk("en_low_hold", 128'(free_count), 128'(4'd4));
    chk("pre_rb_oldest", 128'(issue_rob_idx), 128'(5'd14));
    rollback_en = 1'b1;
    rollback_rob_idx = 5'd10;
    rollback_diff = 5'd4;
    dispatch_en = 1'b1;
    #1;
    chk("rb_cycle_valid",   128'(issue_valid),   128'(1'b1));
    chk("rb_cycle_exclude", 128'(issue_rob_idx), 128'(5'd9));
    step();
    rollback_en = 1'b0;
    dispatch_en = 1'b0;
    chk("rb_free", 128'(free_count), 128'(4'd6));
    push_exp(5'd9, 6'd20, 6'd21);
    expect_issue("rb_survivor9");
    cdb_valid = 2'b01;
    cdb_T_idx = {6'd0, 6'd51};
    step();
    cdb_valid = '0;
    push_exp(5'd15, 6'd51, 6'd25);
    expect_issue("rb_survivor15");
    chk("rb_dispatch_dropped", 128'(free_count), 128'(4'd8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_multi_issue.md
Name: rs_multi_issue

Overview:
- Parametrised reservation station for one functional-unit class. Holds NUM_ENTRIES in-flight instructions, not one entry per FU.
- Wakes operands from NUM_CDB parallel CDB ports and issues the oldest ready entry (ROB order) through a valid/ready handshake.
- Supports ROB-distance rollback squash.
- Sits between dispatch (decoder, map table, free list) and the FU issue stage.

Parameters:
NUM_ENTRIES, 8, station depth (power of 2, >=2)
NUM_CDB, 2, parallel completion broadcast ports
NUM_ROB, 32, ROB depth; ROB_W = $clog2(NUM_ROB)
NUM_PR, 64, physical registers; PR_W = $clog2(NUM_PR)
ZERO_PR, 31, hard-zero physical tag, never broadcast-matched
PAYLOAD_W, 128, opaque packet (inst, func, NPC, dest, selects, branch flags, FL_idx, T_idx)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
en  in  1  global advance; low freezes all state
dispatch_en  in  1  dispatch request
dispatch_payload  in  PAYLOAD_W  instruction packet
dispatch_rob_idx  in  ROB_W  ROB slot of dispatched inst
dispatch_T1_idx / dispatch_T2_idx  in  PR_W each  source tags
dispatch_T1_ready / dispatch_T2_ready  in  1 each  map-table ready bits
cdb_valid  in  NUM_CDB  broadcast valid per port
cdb_T_idx  in  NUM_CDB*PR_W  broadcast tags
rob_head_idx  in  ROB_W  oldest ROB slot, age reference
rollback_en  in  1  squash request
rollback_rob_idx  in  ROB_W  first squashed ROB slot
rollback_diff  in  ROB_W  (ROB tail - rollback_rob_idx) mod NUM_ROB
issue_ready  in  1  FU accepts
issue_valid  out  1  selected entry offered
issue_payload  out  PAYLOAD_W
issue_rob_idx  out  ROB_W
issue_T1_idx / issue_T2_idx  out  PR_W each  for register-file read
rs_ready  out  1  at least one free entry
free_count  out  $clog2(NUM_ENTRIES)+1  free entries

Behaviour:
- Reset, asynchronous: all entries not busy, ready bits 0. issue_valid=0, rs_ready=1, free_count=NUM_ENTRIES.
- Hit on an operand: any p with cdb_valid[p], cdb_T_idx[p]==tag, tag!=ZERO_PR. The ready bit is registered next edge. Multiple ports hitting the same tag is harmless (OR).
- Dispatch: when dispatch_en && rs_ready && en && !rollback_en, allocate the lowest-index free entry. Stored ready = dispatch_Tx_ready OR a same-cycle CDB hit on that tag. No wakeup is lost.
- dispatch_en while !rs_ready is ignored; the upstream stage must stall. rs_ready and free_count are derived from registered state only. A slot freed this cycle is not reusable until the next cycle.
- Issue candidates: busy && T1.ready && T2.ready, using registered bits. A same-cycle CDB hit does not make an entry issuable, so minimum wakeup-to-issue latency is 1 cycle.
- Select: minimum (rob_idx - rob_head_idx) mod NUM_ROB; ties are impossible. Candidates squashed this cycle are excluded.
- issue_valid = en && any candidate. Outputs are combinational from the selected entry.
- Issue handshake: issue_valid && issue_ready && en frees the entry at the next edge. With issue_ready low the entry stays and selection re-evaluates every cycle; an older entry may preempt it.
- Squash: entry is squashed if busy && rollback_en && (rob_idx - rollback_rob_idx) mod NUM_ROB <= rollback_diff. It is freed next edge. Dispatch is suppressed in a rollback cycle.
- Priority per entry: reset > squash > issue-free > wakeup update.
- en low: no state change; issue_valid=0; rs_ready/free_count still reflect state.
- ROB indices wrap modulo NUM_ROB in all subtractions (ROB_W-bit arithmetic).

Decomposition:
- rs_pkg: RS_ENTRY_t (busy, rob_idx, payload, T1/T2 {idx, ready}), RS_ENTRY_RESET, width localparams.
- Sub-module rs_age_select: NUM_ENTRIES-way oldest-first picker (request vector + ages in, one-hot grant + index + any out). Tree-structured for timing.

Test Plan:
- Reset mid-operation with 5 busy entries -> same cycle: issue_valid=0, free_count=8, rs_ready=1.
- Dispatch T1=5 not ready, T2 ready, with cdb_valid=01, cdb_T_idx[0]=5 in same cycle -> entry captured ready; issue_valid=1 next cycle.
- Fill 8 entries, 9th dispatch_en -> ignored, rs_ready=0. Issue one with issue_ready=1 -> rs_ready=1 the following cycle.
- rob_head=30; ready entries at ROB 1, 31, 3 -> issue order 31, 1, 3 with issue_ready held high.
- Two CDB ports waking T1=7 and T2=9 of one entry in the same cycle -> issuable next cycle. Broadcast tag 31 (ZERO_PR) -> no wakeup.
- rollback_rob_idx=10, rollback_diff=4, entries at ROB 9, 10, 14, 15 -> 10 and 14 freed, free_count+=2. A ready ROB 14 is not issued that cycle. A concurrent dispatch is dropped.
